// File: rtl/sdemux_if.sv
// Word-in / slice-out handshake bundle for sdemux.
// Slave side is the demux, master side feeds words and drains slices.
interface sdemux_if #(
  parameter int SLICE_W = 34,
  parameter int NSLICE  = 4
);
  localparam int W = SLICE_W * NSLICE;

  logic               mux_flag;
  logic [W-1:0]       data_in_1;
  logic [W-1:0]       data_in_2;
  logic               in_valid;
  logic               in_ready;
  logic [SLICE_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_idx;
  logic               out_last;
  logic               busy;

  modport master (
    output mux_flag, data_in_1, data_in_2,
    output in_valid, out_ready,
    input  in_ready, out_data, out_valid,
    input  out_idx, out_last, busy
  );

  modport slave (
    input  mux_flag, data_in_1, data_in_2,
    input  in_valid, out_ready,
    output in_ready, out_data, out_valid,
    output out_idx, out_last, busy
  );
endinterface

// File: rtl/sdemux.sv
// Captures one of two wide words and emits it as
// NSLICE narrow slices, LSB slice first.
module sdemux #(
  parameter int SLICE_W = 34,
  parameter int NSLICE  = 4
) (
  input  logic     clk,
  input  logic     rst,
  sdemux_if.slave  bus
);
  localparam int W = SLICE_W * NSLICE;
  localparam logic [1:0] LAST_IDX = 2'(NSLICE - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state;
  state_t       nstate;
  logic [1:0]   idx;
  logic [W-1:0] hold;
  logic         last;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (in_fire) nstate = SEND;
      SEND: if (out_fire && last && !in_fire)
              nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.in_ready  = 1'b0;
    last          = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        bus.in_ready = 1'b1;
      end
      (state == SEND): begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        last          = (idx == LAST_IDX);
        // refill on the final slice so words stream without a gap
        bus.in_ready  = bus.out_ready & last;
      end
      default: ;
    endcase
  end

  assign bus.out_last = last;
  assign bus.out_idx  = idx;
  assign bus.out_data = hold[int'(idx)*SLICE_W +: SLICE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
      idx  <= '0;
    end else if (in_fire) begin
      hold <= bus.mux_flag ? bus.data_in_1 : bus.data_in_2;
      idx  <= '0;
    end else if (out_fire && !last) begin
      idx  <= idx + 2'd1;
    end
  end
endmodule

// File: tb/tb_sdemux.sv
// Randomized and directed bench for sdemux against a
// queue-of-pending-slices reference model.
module tb_sdemux;
  localparam int SW = 34;
  localparam int NS = 4;
  localparam int W  = SW * NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_tx  = 0;

  logic [SW-1:0] q[$];

  sdemux_if #(.SLICE_W(SW), .NSLICE(NS)) bus ();

  sdemux #(.SLICE_W(SW), .NSLICE(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] got,
                     logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Check one cycle against the model, then advance a clock.
  task automatic tick();
    bit ev, eir;
    logic [W-1:0] w;
    #1;
    ev  = (q.size() != 0);
    eir = !ev || (q.size() == 1 && bus.out_ready);
    chk("out_valid", bus.out_valid, ev);
    chk("busy", bus.busy, ev);
    chk("in_ready", bus.in_ready, eir);
    if (ev) begin
      chk("out_data", bus.out_data, q[0]);
      chk("out_idx", bus.out_idx, NS - q.size());
      chk("out_last", bus.out_last, q.size() == 1);
    end else begin
      chk("out_last_idle", bus.out_last, 0);
    end
    if (ev && bus.out_ready) begin
      void'(q.pop_front());
      n_tx++;
    end
    if (bus.in_valid && eir) begin
      w = bus.mux_flag ? bus.data_in_1 : bus.data_in_2;
      for (int i = 0; i < NS; i++) q.push_back(w[i*SW +: SW]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(bit f, logic [W-1:0] a,
                       logic [W-1:0] b);
    bus.mux_flag  = f;
    bus.data_in_1 = a;
    bus.data_in_2 = b;
    bus.in_valid  = 1'b1;
  endtask

  initial begin
    logic [W-1:0] wa, wb;
    int t0;
    bus.mux_flag  = 1'b0;
    bus.data_in_1 = '0;
    bus.data_in_2 = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single word, slices 1..4 LSB first
    wa = {34'h4, 34'h3, 34'h2, 34'h1};
    bus.out_ready = 1'b1;
    offer(1'b1, wa, '0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // source select picks data_in_2
    offer(1'b0, '1, '0);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // backpressure at idx 1, inputs toggled while busy
    offer(1'b1, {34'hd, 34'hc, 34'hb, 34'ha}, '1);
    tick();
    bus.in_valid = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(i[0], rnd_word(), rnd_word());
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // back-to-back words, zero bubble
    t0 = n_tx;
    wa = rnd_word();
    wb = rnd_word();
    offer(1'b1, wa, wb);
    tick();
    offer(1'b0, wa, wb);
    for (int i = 0; i < 4; i++) tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("b2b_count", n_tx - t0, 8);

    // asynchronous reset mid-word
    offer(1'b1, rnd_word(), '0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_idx", bus.out_idx, 0);
    chk("mid_rst_data", bus.out_data, 0);
    q.delete();
    #1 rst = 1'b0;
    chk("post_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    offer(1'b0, '0, rnd_word());
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.mux_flag  = $urandom_range(0, 1) != 0;
      bus.data_in_1 = rnd_word();
      bus.data_in_2 = rnd_word();
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("drained", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
